// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF fetches and MEM loads/stores onto one byte-wide RAM port, little-endian.
// Latency: fetch/load done in cycle N+2 after the grant edge, store done in cycle N+1 (N = bytes).
// Backpressure: requesters hold req until done; stallreq_if/stallreq_mem freeze the pipeline meanwhile.
// Optional feature: define MEM_CTRL_IFBUF_EN for a one-entry fetch buffer (a hit completes the next cycle).
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_inst,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;      // cycles since grant minus one
    logic [2:0]        len_q, len_d;      // bytes in this transaction (1, 2 or 4)
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [23:0]       asm_q, asm_d;      // lower bytes of a read, assembled as they return
    logic [31:0]       if_inst_q, if_inst_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic              access;            // a RAM byte access is presented this cycle
    logic              rd_done;           // done cycle of a FETCH or LOAD
    logic              st_done;           // done cycle of a STORE

    // Upper address bits above the RAM width are intentionally ignored.
    logic              unused_mem_hi;
    assign unused_mem_hi = ^mem_addr[31:ADDR_W];

`ifdef MEM_CTRL_IFBUF_EN
    logic              buf_vld_q, buf_vld_d;
    logic [31:0]       buf_addr_q, buf_addr_d;
    logic [31:0]       buf_inst_q, buf_inst_d;
    logic [31:0]       fetch_addr_q, fetch_addr_d;  // full fetch address, tags the buffer
    logic              buf_hit;
`else
    logic              unused_if_hi;
    assign unused_if_hi = ^if_addr[31:ADDR_W];
`endif

    // Byte count for a load/store; the reserved size 11 behaves as a word.
    function automatic logic [2:0] len_of(input logic [1:0] size);
        case (size)
            2'b00:   len_of = 3'd1;
            2'b01:   len_of = 3'd2;
            default: len_of = 3'd4;
        endcase
    endfunction

    // Phase decode: access cycles are cnt 0..N-1, reads finish one cycle after the last byte returns.
    always_comb begin
        access  = (state_q != IDLE) && (cnt_q < len_q);
        rd_done = ((state_q == FETCH) || (state_q == LOAD)) && (cnt_q == len_q + 3'd1);
        st_done = (state_q == STORE) && (cnt_q == len_q);
    end

    // RAM port drive: address base+cnt wraps naturally at ADDR_W bits; quiet outside access cycles.
    always_comb begin
        ram_addr = '0;
        ram_wr   = 1'b0;
        ram_dout = '0;
        if (access) begin
            ram_addr = base_q + ADDR_W'(cnt_q);
            if (state_q == STORE) begin
                ram_wr = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    ram_dout = wdata_q[7:0];
                    2'd1:    ram_dout = wdata_q[15:8];
                    2'd2:    ram_dout = wdata_q[23:16];
                    default: ram_dout = wdata_q[31:24];
                endcase
            end
        end
    end

    assign if_done      = rd_done && (state_q == FETCH);
    assign mem_done     = (rd_done && (state_q == LOAD)) || st_done;
    assign stallreq_if  = if_req & ~if_done & ~if_flush;
    assign stallreq_mem = mem_req & ~mem_done;
    assign if_inst      = if_inst_q;
    assign mem_rdata    = mem_rdata_q;

    // Next-state: arbitration in IDLE, byte sequencing and read assembly in the busy states.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
`ifdef MEM_CTRL_IFBUF_EN
        buf_vld_d    = buf_vld_q;
        buf_addr_d   = buf_addr_q;
        buf_inst_d   = buf_inst_q;
        fetch_addr_d = fetch_addr_q;
        buf_hit      = buf_vld_q && (buf_addr_q == if_addr);
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // MEM holds the older instruction, so it wins over IF.
                if (mem_req) begin
                    state_d = mem_we ? STORE : LOAD;
                    base_d  = mem_addr[ADDR_W-1:0];
                    len_d   = len_of(mem_size);
                    wdata_d = mem_wdata;
`ifdef MEM_CTRL_IFBUF_EN
                    // Any store may alias the buffered word.
                    if (mem_we) buf_vld_d = 1'b0;
`endif
                end else if (if_req && !if_flush) begin
                    state_d = FETCH;
                    base_d  = if_addr[ADDR_W-1:0];
                    len_d   = 3'd4;
`ifdef MEM_CTRL_IFBUF_EN
                    fetch_addr_d = if_addr;
                    // A hit jumps straight to the done cycle with the buffered word.
                    if (buf_hit) begin
                        cnt_d     = 3'd5;
                        if_inst_d = buf_inst_q;
                    end
`endif
                end
            end
            FETCH: begin
                if (rd_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef MEM_CTRL_IFBUF_EN
                    buf_vld_d  = 1'b1;
                    buf_addr_d = fetch_addr_q;
                    buf_inst_d = if_inst_q;
`endif
                end else if (if_flush) begin
                    // Abort: the last byte is never committed, so if_inst keeps its old value.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    case (cnt_q)
                        3'd1:    asm_d[7:0]   = ram_din;
                        3'd2:    asm_d[15:8]  = ram_din;
                        3'd3:    asm_d[23:16] = ram_din;
                        default: ;
                    endcase
                    if (cnt_q == len_q) if_inst_d = {ram_din, asm_q};
                end
            end
            LOAD: begin
                if (rd_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    case (cnt_q)
                        3'd1:    asm_d[7:0]   = ram_din;
                        3'd2:    asm_d[15:8]  = ram_din;
                        3'd3:    asm_d[23:16] = ram_din;
                        default: ;
                    endcase
                    // Last byte arrives: commit the zero-extended result.
                    if (cnt_q == len_q) begin
                        case (len_q)
                            3'd1:    mem_rdata_d = {24'd0, ram_din};
                            3'd2:    mem_rdata_d = {16'd0, ram_din, asm_q[7:0]};
                            default: mem_rdata_d = {ram_din, asm_q};
                        endcase
                    end
                end
            end
            STORE: begin
                if (st_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-store simply abandons the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
`ifdef MEM_CTRL_IFBUF_EN
            buf_vld_q    <= 1'b0;
            buf_addr_q   <= '0;
            buf_inst_q   <= '0;
            fetch_addr_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef MEM_CTRL_IFBUF_EN
            buf_vld_q    <= buf_vld_d;
            buf_addr_q   <= buf_addr_d;
            buf_inst_q   <= buf_inst_d;
            fetch_addr_q <= fetch_addr_d;
`endif
        end
    end

endmodule
